// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing one single-ported data memory between the GPP and the CP.
// Round-robin on contention, CP burst lock with a starvation bound, registered read-return routing.
module data_mem_arbiter #(
    parameter int MAX_LOCK = 8,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gpp_req,
    input  logic          gpp_we,
    input  logic [AW-1:0] gpp_addr,
    input  logic [DW-1:0] gpp_wdata,
    output logic          gpp_gnt,
    output logic          gpp_rvalid,
    output logic [DW-1:0] gpp_rdata,
    input  logic          cp_req,
    input  logic          cp_we,
    input  logic          cp_lock,
    input  logic [AW-1:0] cp_addr,
    input  logic [DW-1:0] cp_wdata,
    output logic          cp_gnt,
    output logic          cp_rvalid,
    output logic [DW-1:0] cp_rdata,
    output logic [AW-1:0] address_rw,
    output logic [DW-1:0] data_in,
    output logic          memory_write_enable,
    input  logic [DW-1:0] data_out
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GPP_LAST  = 2'd1;
    localparam logic [1:0] CP_LAST   = 2'd2;
    localparam logic [1:0] CP_LOCKED = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    lock_cnt_reg, lock_cnt_next;
    logic          lock_expired;
    logic          gpp_win, cp_win;
    logic          rd_pend_reg, rd_tag_reg;
    logic [DW-1:0] gpp_hold_reg, cp_hold_reg;

    assign lock_expired = (lock_cnt_reg >= 4'(MAX_LOCK));

    // Winner selection; purely combinational so a grant lands in the request cycle.
    always_comb begin
        gpp_win = 1'b0;
        cp_win  = 1'b0;
        if (state_reg == CP_LOCKED) begin
            if (gpp_req && lock_expired) begin
                gpp_win = 1'b1;
            end else if (cp_req) begin
                cp_win = 1'b1;
            end else if (gpp_req) begin
                gpp_win = 1'b1;
            end
        end else if (gpp_req && cp_req) begin
            if (state_reg == GPP_LAST) begin
                cp_win = 1'b1;
            end else begin
                gpp_win = 1'b1;
            end
        end else begin
            gpp_win = gpp_req;
            cp_win  = cp_req;
        end
    end

    // Grants are held off while reset is asserted.
    assign gpp_gnt = gpp_win & rst;
    assign cp_gnt  = cp_win & rst;

    always_comb begin
        address_rw          = '0;
        data_in             = '0;
        memory_write_enable = 1'b0;
        if (gpp_gnt) begin
            address_rw          = gpp_addr;
            data_in             = gpp_wdata;
            memory_write_enable = gpp_we;
        end else if (cp_gnt) begin
            address_rw          = cp_addr;
            data_in             = cp_wdata;
            memory_write_enable = cp_we;
        end
    end

    // The lock counter only advances while GPP is actually being held off.
    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        if (gpp_win) begin
            state_next    = GPP_LAST;
            lock_cnt_next = '0;
        end else if (cp_win) begin
            if (cp_lock) begin
                state_next = CP_LOCKED;
                if (state_reg != CP_LOCKED) begin
                    lock_cnt_next = '0;
                end else if (gpp_req && !lock_expired) begin
                    lock_cnt_next = lock_cnt_reg + 4'd1;
                end
            end else begin
                state_next    = CP_LAST;
                lock_cnt_next = '0;
            end
        end else if (!(state_reg == CP_LOCKED && cp_lock)) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // Read-return tag: one pending read at most, owner recorded at grant time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_reg  <= 1'b0;
            rd_tag_reg   <= 1'b0;
            gpp_hold_reg <= '0;
            cp_hold_reg  <= '0;
        end else begin
            rd_pend_reg <= (gpp_gnt & ~gpp_we) | (cp_gnt & ~cp_we);
            rd_tag_reg  <= cp_gnt;
            if (gpp_rvalid) begin
                gpp_hold_reg <= data_out;
            end
            if (cp_rvalid) begin
                cp_hold_reg <= data_out;
            end
        end
    end

    assign gpp_rvalid = rd_pend_reg & ~rd_tag_reg;
    assign cp_rvalid  = rd_pend_reg & rd_tag_reg;
    assign gpp_rdata  = gpp_rvalid ? data_out : gpp_hold_reg;
    assign cp_rdata   = cp_rvalid ? data_out : cp_hold_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/memory model.
module tb_data_mem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_LOCK = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          gpp_req = 1'b0, gpp_we = 1'b0;
    logic [AW-1:0] gpp_addr = '0;
    logic [DW-1:0] gpp_wdata = '0;
    logic          gpp_gnt, gpp_rvalid;
    logic [DW-1:0] gpp_rdata;
    logic          cp_req = 1'b0, cp_we = 1'b0, cp_lock = 1'b0;
    logic [AW-1:0] cp_addr = '0;
    logic [DW-1:0] cp_wdata = '0;
    logic          cp_gnt, cp_rvalid;
    logic [DW-1:0] cp_rdata;
    logic [AW-1:0] address_rw;
    logic [DW-1:0] data_in;
    logic          memory_write_enable;
    logic [DW-1:0] data_out = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MAX_LOCK(MAX_LOCK), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .gpp_req(gpp_req), .gpp_we(gpp_we), .gpp_addr(gpp_addr), .gpp_wdata(gpp_wdata),
        .gpp_gnt(gpp_gnt), .gpp_rvalid(gpp_rvalid), .gpp_rdata(gpp_rdata),
        .cp_req(cp_req), .cp_we(cp_we), .cp_lock(cp_lock), .cp_addr(cp_addr),
        .cp_wdata(cp_wdata), .cp_gnt(cp_gnt), .cp_rvalid(cp_rvalid), .cp_rdata(cp_rdata),
        .address_rw(address_rw), .data_in(data_in),
        .memory_write_enable(memory_write_enable), .data_out(data_out)
    );

    // Environment memory: synchronous, read data one cycle after the address.
    logic [DW-1:0] env_mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (memory_write_enable) env_mem[address_rw] <= data_in;
        data_out <= env_mem[address_rw];
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return 16'((a * 16'h9E37) ^ 16'h5A5A);
    endfunction

    task automatic drive(input logic gr, gw, input logic [15:0] ga, gd,
                         input logic cr, cw, cl, input logic [15:0] ca, cd);
        @(negedge clk);
        gpp_req = gr; gpp_we = gw; gpp_addr = ga; gpp_wdata = gd;
        cp_req = cr; cp_we = cw; cp_lock = cl; cp_addr = ca; cp_wdata = cd;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_last;      // 0 none, 1 gpp, 2 cp
    bit            m_locked;
    int            m_starve;    // locked CP wins while GPP was waiting
    bit            m_pend_g, m_pend_c;
    logic [DW-1:0] m_pend_data, m_hold_g, m_hold_c;
    int            e_win;
    logic          e_rvg, e_rvc, e_we;
    logic [DW-1:0] e_rdg, e_rdc, e_din;
    logic [AW-1:0] e_addr;

    task automatic model_reset();
        m_last = 0; m_locked = 0; m_starve = 0;
        m_pend_g = 0; m_pend_c = 0; m_pend_data = '0; m_hold_g = '0; m_hold_c = '0;
    endtask

    task automatic model_eval();
        e_win = 0;
        if (m_locked && gpp_req && m_starve >= MAX_LOCK) e_win = 1;
        else if (m_locked && cp_req) e_win = 2;
        else if (gpp_req && cp_req) e_win = (m_last == 1) ? 2 : 1;
        else if (gpp_req) e_win = 1;
        else if (cp_req) e_win = 2;
        e_addr = (e_win == 1) ? gpp_addr : (e_win == 2) ? cp_addr : '0;
        e_din  = (e_win == 1) ? gpp_wdata : (e_win == 2) ? cp_wdata : '0;
        e_we   = (e_win == 1) ? gpp_we : (e_win == 2) ? cp_we : 1'b0;
        e_rvg  = m_pend_g;
        e_rvc  = m_pend_c;
        e_rdg  = m_pend_g ? m_pend_data : m_hold_g;
        e_rdc  = m_pend_c ? m_pend_data : m_hold_c;
    endtask

    task automatic model_commit();
        if (m_pend_g) m_hold_g = m_pend_data;
        if (m_pend_c) m_hold_c = m_pend_data;
        m_pend_g = (e_win == 1) && !gpp_we;
        m_pend_c = (e_win == 2) && !cp_we;
        if (e_win != 0) m_pend_data = ref_mem[e_addr];
        if (e_win != 0 && e_we) ref_mem[e_addr] = e_din;
        if (e_win == 0) begin
            if (!(m_locked && cp_lock)) begin m_last = 0; m_locked = 0; end
        end else if (e_win == 1) begin
            m_last = 1; m_locked = 0;
        end else begin
            m_last = 2;
            if (cp_lock) begin
                if (!m_locked) m_starve = 0;
                else if (gpp_req) m_starve++;
                m_locked = 1;
            end else begin
                m_locked = 0;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0041, 16'h5678);
        checks++; if (gpp_gnt !== 1'b0 || cp_gnt !== 1'b0)
            begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", gpp_gnt, cp_gnt); end
        checks++; if (memory_write_enable !== 1'b0)
            begin errors++; $display("FAIL reset_we got=%b exp=0", memory_write_enable); end
        checks++; if (address_rw !== '0)
            begin errors++; $display("FAIL reset_addr got=%h exp=0000", address_rw); end
        checks++; if (gpp_rvalid !== 1'b0 || cp_rvalid !== 1'b0)
            begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", gpp_rvalid, cp_rvalid); end
        checks++; if (gpp_rdata !== '0 || cp_rdata !== '0)
            begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", gpp_rdata, cp_rdata); end
        $display("txn reset held, requests masked");
    endtask

    task automatic test_single_read();
        @(negedge clk);
        gpp_req = 1'b1; gpp_we = 1'b0; gpp_addr = 16'h0010;
        cp_req = 1'b0; cp_we = 1'b0; cp_lock = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (gpp_gnt !== 1'b1 || cp_gnt !== 1'b0)
            begin errors++; $display("FAIL single_gnt got=%b%b exp=10", gpp_gnt, cp_gnt); end
        checks++; if (address_rw !== 16'h0010 || memory_write_enable !== 1'b0)
            begin errors++; $display("FAIL single_addr got=%h we=%b exp=0010 we=0", address_rw, memory_write_enable); end
        idle_cycle();
        checks++; if (gpp_rvalid !== 1'b1 || cp_rvalid !== 1'b0 || gpp_rdata !== init_val(16'h0010))
            begin errors++; $display("FAIL single_rdata got=%b%b %h exp=10 %h", gpp_rvalid, cp_rvalid, gpp_rdata, init_val(16'h0010)); end
        idle_cycle();
        checks++; if (gpp_rvalid !== 1'b0 || gpp_rdata !== init_val(16'h0010))
            begin errors++; $display("FAIL single_hold got=%b %h exp=0 %h", gpp_rvalid, gpp_rdata, init_val(16'h0010)); end
        $display("txn gpp read 0010 -> %h", gpp_rdata);
    endtask

    task automatic test_rr_writes();
        logic [15:0] ga, ca, gd, cd;
        logic        eg;
        for (int k = 0; k < 4; k++) begin
            ga = 16'(16'h0100 + k); ca = 16'(16'h0180 + k);
            gd = 16'(16'hA000 + k); cd = 16'(16'hC000 + k);
            drive(1'b1, 1'b1, ga, gd, 1'b1, 1'b1, 1'b0, ca, cd);
            eg = (k % 2 == 0);
            checks++; if (gpp_gnt !== eg || cp_gnt !== !eg)
                begin errors++; $display("FAIL rr_gnt k=%0d got=%b%b exp=%b%b", k, gpp_gnt, cp_gnt, eg, !eg); end
            checks++; if (memory_write_enable !== 1'b1 || address_rw !== (eg ? ga : ca) || data_in !== (eg ? gd : cd))
                begin errors++; $display("FAIL rr_bus k=%0d got=%b %h %h", k, memory_write_enable, address_rw, data_in); end
            checks++; if (gpp_rvalid !== 1'b0 || cp_rvalid !== 1'b0)
                begin errors++; $display("FAIL rr_rvalid k=%0d got=%b%b exp=00", k, gpp_rvalid, cp_rvalid); end
            $display("txn rr write k=%0d winner=%s", k, gpp_gnt ? "gpp" : "cp");
        end
        idle_cycle();
        checks++; if (gpp_rvalid !== 1'b0 || cp_rvalid !== 1'b0)
            begin errors++; $display("FAIL rr_tail_rvalid got=%b%b exp=00", gpp_rvalid, cp_rvalid); end
    endtask

    task automatic test_lock_burst();
        int n_cp;
        drive(1'b0, 1'b1, 16'h0200, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0201, 16'hBEEF);
        checks++; if (cp_gnt !== 1'b1)
            begin errors++; $display("FAIL lock_entry got=%b exp=1", cp_gnt); end
        n_cp = 0;
        for (int k = 0; k < MAX_LOCK; k++) begin
            drive(1'b1, 1'b1, 16'h0200, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h0201, 16'hBEEF);
            if (cp_gnt === 1'b1 && gpp_gnt === 1'b0) n_cp++;
        end
        checks++; if (n_cp != MAX_LOCK)
            begin errors++; $display("FAIL lock_cp_count got=%0d exp=%0d", n_cp, MAX_LOCK); end
        drive(1'b1, 1'b1, 16'h0200, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h0201, 16'hBEEF);
        checks++; if (gpp_gnt !== 1'b1 || cp_gnt !== 1'b0)
            begin errors++; $display("FAIL lock_release got=%b%b exp=10", gpp_gnt, cp_gnt); end
        drive(1'b1, 1'b1, 16'h0200, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h0201, 16'hBEEF);
        checks++; if (gpp_gnt !== 1'b0 || cp_gnt !== 1'b1)
            begin errors++; $display("FAIL lock_cp_again got=%b%b exp=01", gpp_gnt, cp_gnt); end
        $display("txn lock burst cp=%0d then gpp then cp", n_cp);
        idle_cycle();
    endtask

    task automatic test_alt_reads();
        bit prev_g;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0);
            else idle_cycle();
            if (k < 4) begin
                checks++; if (gpp_gnt !== (k % 2 == 0) || cp_gnt !== (k % 2 == 1))
                    begin errors++; $display("FAIL alt_gnt k=%0d got=%b%b", k, gpp_gnt, cp_gnt); end
            end
            if (k > 0) begin
                prev_g = ((k - 1) % 2 == 0);
                checks++;
                if (prev_g && (gpp_rvalid !== 1'b1 || cp_rvalid !== 1'b0 || gpp_rdata !== init_val(1))) begin
                    errors++; $display("FAIL alt_gpp_ret k=%0d got=%b%b %h exp=10 %h", k, gpp_rvalid, cp_rvalid, gpp_rdata, init_val(1));
                end else if (!prev_g && (cp_rvalid !== 1'b1 || gpp_rvalid !== 1'b0 || cp_rdata !== init_val(2))) begin
                    errors++; $display("FAIL alt_cp_ret k=%0d got=%b%b %h exp=01 %h", k, gpp_rvalid, cp_rvalid, cp_rdata, init_val(2));
                end
            end
            $display("txn alt read k=%0d gnt=%b%b rv=%b%b", k, gpp_gnt, cp_gnt, gpp_rvalid, cp_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0);
        checks++; if (cp_gnt !== 1'b1)
            begin errors++; $display("FAIL midrst_gnt got=%b exp=1", cp_gnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        gpp_req = 1'b1; gpp_we = 1'b1; gpp_addr = 16'h0300; gpp_wdata = 16'h7777;
        #1;
        checks++; if (cp_rvalid !== 1'b0 || cp_gnt !== 1'b0 || gpp_gnt !== 1'b0 || memory_write_enable !== 1'b0)
            begin errors++; $display("FAIL midrst_hold rv=%b gnt=%b%b we=%b exp=0 00 0", cp_rvalid, gpp_gnt, cp_gnt, memory_write_enable); end
        @(negedge clk);
        cp_we = 1'b0; cp_lock = 1'b1; cp_req = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (gpp_gnt !== 1'b1 || cp_gnt !== 1'b0 || cp_rvalid !== 1'b0)
            begin errors++; $display("FAIL midrst_idle gnt=%b%b rv=%b exp=10 0", gpp_gnt, cp_gnt, cp_rvalid); end
        idle_cycle();
        checks++; if (cp_rvalid !== 1'b0 || gpp_rvalid !== 1'b0)
            begin errors++; $display("FAIL midrst_norv got=%b%b exp=00", gpp_rvalid, cp_rvalid); end
        $display("txn reset mid-read, pending cp read dropped");
    endtask

    task automatic test_idle_return();
        drive(1'b1, 1'b1, 16'h0301, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b1, 16'h0302, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0303, 16'h0003);
        checks++; if (cp_gnt !== 1'b1 || gpp_gnt !== 1'b0)
            begin errors++; $display("FAIL rr_after_gpp got=%b%b exp=01", gpp_gnt, cp_gnt); end
        drive(1'b1, 1'b1, 16'h0304, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) idle_cycle();
        drive(1'b1, 1'b1, 16'h0305, 16'h0005, 1'b1, 1'b1, 1'b0, 16'h0306, 16'h0006);
        checks++; if (gpp_gnt !== 1'b1 || cp_gnt !== 1'b0)
            begin errors++; $display("FAIL idle_return got=%b%b exp=10", gpp_gnt, cp_gnt); end
        $display("txn idle return, gpp wins after gap");
        idle_cycle();
    endtask

    task automatic test_random();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4),
                  16'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 9) < 6), 16'($urandom_range(0, 15)), 16'($urandom));
            model_eval();
            checks++; if (gpp_gnt !== (e_win == 1) || cp_gnt !== (e_win == 2))
                begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp_win=%0d", c, gpp_gnt, cp_gnt, e_win); end
            checks++; if (address_rw !== e_addr || data_in !== e_din || memory_write_enable !== e_we)
                begin errors++; $display("FAIL rnd_bus cyc=%0d got=%h %h %b exp=%h %h %b", c, address_rw, data_in, memory_write_enable, e_addr, e_din, e_we); end
            checks++; if (gpp_rvalid !== e_rvg || cp_rvalid !== e_rvc)
                begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp=%b%b", c, gpp_rvalid, cp_rvalid, e_rvg, e_rvc); end
            checks++; if (gpp_rdata !== e_rdg || cp_rdata !== e_rdc)
                begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", c, gpp_rdata, cp_rdata, e_rdg, e_rdc); end
            $display("txn rnd %0d win=%0d addr=%h we=%b rv=%b%b", c, e_win, e_addr, e_we, e_rvg, e_rvc);
            model_commit();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        test_reset();
        test_single_read();
        test_rr_writes();
        test_lock_burst();
        test_alt_reads();
        test_reset_mid_read();
        test_idle_return();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
